fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, word address of first fetch after reset.
REQ-002 Parameter: QDEPTH, 2, instruction queue depth in entries (fixed at 2 for this revision).
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 CLR  in  1  reset, synchronous, active-high.
REQ-005 StallF  in  1  downstream IF/ID register not accepting (its EN = ~StallF).
REQ-006 RedirectE  in  1  branch/jump taken; flush fetch path.
REQ-007 RedirectPC  in  32  target word address, valid when RedirectE=1.
REQ-008 IMemReq  out  1  instruction memory request valid.
REQ-009 IMemAddr  out  32  word address of request.
REQ-010 IMemReady  in  1  memory accepts request this cycle.
REQ-011 IMemValid  in  1  read data valid this cycle.
REQ-012 IMemRData  in  32  instruction word.
REQ-013 PCp1FOut  out  32  PC+1 of head instruction, to IF/ID PCp1FIn.
REQ-014 InstrFOut  out  32  head instruction, to IF/ID InstrFIn.
REQ-015 ValidF  out  1  queue head valid.

Function
REQ-016 PC register holds next fetch address; PC arithmetic SHALL be 32-bit word-addressed, +1 per instruction, wrap 32'hFFFFFFFF -> 0.
REQ-017 FSM states SHALL be IDLE (no outstanding request), WAIT (one outstanding, response kept), DROP (one outstanding, response discarded); at most one request outstanding.
REQ-018 IMemReq SHALL be 1 only in IDLE with queue count < QDEPTH and CLR=0 and RedirectE=0; IMemAddr SHALL equal PC.
REQ-019 Request transfer = IMemReq & IMemReady: PC <= PC+1, IDLE -> WAIT; no transfer: PC and state hold.
REQ-020 In WAIT with IMemValid=1: enqueue {PCp1=PC, Instr=IMemRData}, WAIT -> IDLE; earliest next request the following cycle.
REQ-021 IMemValid SHALL be ignored in IDLE.
REQ-022 Dequeue SHALL occur on a cycle with ValidF=1 & StallF=0; enqueue and dequeue in the same cycle keep count unchanged.
REQ-023 ValidF=0 SHALL force PCp1FOut=0 and InstrFOut=0 (bubble).
REQ-024 Outputs SHALL be driven from queue head registers; no combinational path from IMemRData to InstrFOut.
REQ-025 RedirectE=1 SHALL have priority: queue emptied, PC <= RedirectPC, no request issued that cycle; WAIT -> DROP, IDLE stays IDLE, DROP stays DROP.
REQ-026 RedirectE=1 in WAIT or DROP with IMemValid=1 the same cycle: response discarded, next state IDLE.
REQ-027 In DROP with IMemValid=1 and RedirectE=0: response discarded, DROP -> IDLE, PC unchanged.
REQ-028 Queue overflow SHALL be impossible by REQ-018; underflow impossible by REQ-022.
REQ-029 Minimum latency: request accepted cycle N, IMemValid cycle N+1, ValidF=1 cycle N+2.

Reset
REQ-030 CLR=1 at a rising edge: PC <= RESET_PC, state <= IDLE, queue count <= 0, head registers <= 0.
REQ-031 While CLR=1: IMemReq=0, ValidF=0, PCp1FOut=0, InstrFOut=0.
REQ-032 CLR mid-operation SHALL abandon any outstanding request; a response arriving after CLR deassertion with state IDLE is ignored per REQ-021.

Structure
REQ-033 Shared package SHALL hold: FSM state enum (IDLE, WAIT, DROP), RESET_PC default, QDEPTH, 64-bit queue entry type {PCp1[31:0], Instr[31:0]}.
REQ-034 One sub-module fetch_queue: QDEPTH-entry synchronous FIFO with push, pop, flush, count, head outputs; flush dominates push.

Verification
REQ-035 Reset, IMemReady=1, memory latency 1, StallF=0, RESET_PC=0 -> IMemAddr 0,1,2 on cycles 1,3,5; ValidF with PCp1FOut=1,2,3 on cycles 3,5,7.
REQ-036 StallF=1 held, memory always ready -> exactly 2 entries queued, IMemReq stays 0 thereafter; release StallF -> entries drain in order, fetch resumes.
REQ-037 RedirectE=1, RedirectPC=32'h40 in WAIT -> state DROP, response discarded, next IMemAddr=32'h40, ValidF=0 until its data arrives.
REQ-038 RedirectE and IMemValid same cycle in WAIT -> no enqueue, state IDLE, next IMemAddr=RedirectPC.
REQ-039 PC=32'hFFFFFFFF fetched -> PCp1FOut=0, next IMemAddr=0.
REQ-040 CLR asserted in WAIT, stale IMemValid one cycle after release -> ValidF stays 0, IMemAddr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_unit_pkg;

  localparam int unsigned XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned QDEPTH_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pcp1;
    logic [XLEN-1:0] instr;
  } q_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between fetch unit and memory.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            IMemReq;
  logic [XLEN-1:0] IMemAddr;
  logic            IMemReady;
  logic            IMemValid;
  logic [XLEN-1:0] IMemRData;

  modport master (
    output IMemReq, IMemAddr,
    input  IMemReady, IMemValid, IMemRData
  );

  modport slave (
    input  IMemReq, IMemAddr,
    output IMemReady, IMemValid, IMemRData
  );
endinterface

// File: rtl/fetch_queue.sv
// Shift-style synchronous FIFO; entry 0 is always the head, flush dominates push.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned QDEPTH = QDEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  q_entry_t                     din,
  output logic [$clog2(QDEPTH+1)-1:0]  count,
  output q_entry_t                     head
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned IW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  q_entry_t        ent [QDEPTH];
  logic [IW-1:0]   wr_idx;

  // A simultaneous pop shifts everything down, so the write slot moves down too.
  assign wr_idx = pop ? IW'(count - CW'(1)) : IW'(count);
  assign head   = ent[0];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) ent[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < QDEPTH - 1; i++) ent[i] <= ent[i+1];
        ent[QDEPTH-1] <= '0;
      end
      if (push) ent[wr_idx] <= din;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small
// instruction queue, with redirect flush and discard of in-flight responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned QDEPTH   = QDEPTH_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              StallF,
  input  logic              RedirectE,
  input  logic [XLEN-1:0]   RedirectPC,
  fetch_unit_if.master      imem,
  output logic [XLEN-1:0]   PCp1FOut,
  output logic [XLEN-1:0]   InstrFOut,
  output logic              ValidF
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   count;
  q_entry_t        head;
  q_entry_t        din;
  logic            req;
  logic            push;
  logic            pop;

  assign req  = (state == IDLE) && (count < CW'(QDEPTH)) && !CLR && !RedirectE;
  assign push = (state == WAIT) && imem.IMemValid && !RedirectE && !CLR;
  assign pop  = ValidF && !StallF;
  assign din  = '{pcp1: pc, instr: imem.IMemRData};

  assign imem.IMemReq  = req;
  assign imem.IMemAddr = pc;

  // Head comes straight from queue registers; invalid head reads as a bubble.
  assign ValidF    = (count != '0) && !CLR;
  assign PCp1FOut  = ValidF ? head.pcp1  : '0;
  assign InstrFOut = ValidF ? head.instr : '0;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      pc    <= RESET_PC;
      state <= IDLE;
    end else if (RedirectE) begin
      pc    <= RedirectPC;
      // An in-flight request with no response yet must have its data dropped.
      state <= (state == IDLE || imem.IMemValid) ? IDLE : DROP;
    end else begin
      case (state)
        IDLE: begin
          if (req && imem.IMemReady) begin
            pc    <= pc + 32'd1;
            state <= WAIT;
          end
        end
        WAIT:    if (imem.IMemValid) state <= IDLE;
        DROP:    if (imem.IMemValid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (CLK),
    .rst   (CLR),
    .flush (RedirectE),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a latency-programmable memory.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        StallF = 1'b0;
  logic        RedirectE = 1'b0;
  logic [31:0] RedirectPC = 32'h0;
  logic [31:0] PCp1FOut;
  logic [31:0] InstrFOut;
  logic        ValidF;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0), .QDEPTH(2)) dut (
    .CLK        (CLK),
    .CLR        (CLR),
    .StallF     (StallF),
    .RedirectE  (RedirectE),
    .RedirectPC (RedirectPC),
    .imem       (imem),
    .PCp1FOut   (PCp1FOut),
    .InstrFOut  (InstrFOut),
    .ValidF     (ValidF)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pcp1;
    logic [31:0] instr;
  } obs_t;

  obs_t        obs;
  obs_t        exp;
  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // One cycle: drive at negedge, sample 1ns later, memory answers lat cycles after accept.
  task automatic tick(input logic stall, input logic redir, input logic [31:0] rpc);
    StallF     = stall;
    RedirectE  = redir;
    RedirectPC = rpc;
    if (pend_cnt == 1) begin
      imem.IMemValid = 1'b1;
      imem.IMemRData = instr_of(pend_addr);
    end else begin
      imem.IMemValid = 1'b0;
      imem.IMemRData = 32'hDEAD_BEEF;
    end
    #1;
    obs.req   = imem.IMemReq;
    obs.addr  = imem.IMemReq ? imem.IMemAddr : 32'h0;
    obs.valid = ValidF;
    obs.pcp1  = PCp1FOut;
    obs.instr = InstrFOut;
    if (pend_cnt != 0) pend_cnt--;
    if (imem.IMemReq && imem.IMemReady) begin
      pend_cnt  = lat;
      pend_addr = imem.IMemAddr;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    pend_cnt = 0;
    tick(1'b0, 1'b0, 32'h0);
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
    CLR = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
  endtask

  task automatic test_sequential();
    do_reset();
    lat = 1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, 32'h0);
      exp = {1'b1, 32'(k), (k > 0), (k > 0) ? 32'(k) : 32'h0, (k > 0) ? instr_of(32'(k - 1)) : 32'h0};
      checks++; if (obs !== exp) begin failures++; $display("FAIL seq_req k=%0d got=%h exp=%h", k, obs, exp); end
      tick(1'b0, 1'b0, 32'h0);
      exp = '0;
      checks++; if (obs !== exp) begin failures++; $display("FAIL seq_wait k=%0d got=%h exp=%h", k, obs, exp); end
    end
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h3, 1'b1, 32'h3, instr_of(32'h2)};
    checks++; if (obs !== exp) begin failures++; $display("FAIL seq_c7 got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_stall();
    obs_t tbl [11];
    logic stl [11];
    do_reset();
    lat = 1;
    stl = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 0};
    tbl[0]  = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '0;
    tbl[2]  = {1'b1, 32'h1, 1'b1, 32'h1, instr_of(32'h0)};
    tbl[3]  = {1'b0, 32'h0, 1'b1, 32'h1, instr_of(32'h0)};
    tbl[4]  = {1'b0, 32'h0, 1'b1, 32'h1, instr_of(32'h0)};
    tbl[5]  = {1'b0, 32'h0, 1'b1, 32'h1, instr_of(32'h0)};
    tbl[6]  = {1'b0, 32'h0, 1'b1, 32'h1, instr_of(32'h0)};
    tbl[7]  = {1'b1, 32'h2, 1'b1, 32'h2, instr_of(32'h1)};
    tbl[8]  = {1'b0, 32'h0, 1'b1, 32'h2, instr_of(32'h1)};
    tbl[9]  = {1'b1, 32'h3, 1'b1, 32'h3, instr_of(32'h2)};
    tbl[10] = '0;
    for (int c = 0; c < 11; c++) begin
      tick(stl[c], 1'b0, 32'h0);
      exp = tbl[c];
      checks++; if (obs !== exp) begin failures++; $display("FAIL stall_c%0d got=%h exp=%h", c + 1, obs, exp); end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    lat = 2;
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL redir_req0 got=%h exp=%h", obs, exp); end
    tick(1'b0, 1'b1, 32'h40);
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL redir_during got=%h exp=%h", obs, exp); end
    tick(1'b0, 1'b0, 32'h0);
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL redir_drop got=%h exp=%h", obs, exp); end
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h40, 1'b0, 32'h0, 32'h0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL redir_target got=%h exp=%h", obs, exp); end
    for (int c = 0; c < 2; c++) begin
      tick(1'b0, 1'b0, 32'h0);
      exp = '0;
      checks++; if (obs !== exp) begin failures++; $display("FAIL redir_bubble%0d got=%h exp=%h", c, obs, exp); end
    end
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h41, 1'b1, 32'h41, instr_of(32'h40)};
    checks++; if (obs !== exp) begin failures++; $display("FAIL redir_data got=%h exp=%h", obs, exp); end
    lat = 1;
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    lat = 1;
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL same_req0 got=%h exp=%h", obs, exp); end
    tick(1'b0, 1'b1, 32'h100);
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL same_redir got=%h exp=%h", obs, exp); end
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h100, 1'b0, 32'h0, 32'h0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL same_target got=%h exp=%h", obs, exp); end
    tick(1'b0, 1'b0, 32'h0);
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL same_wait got=%h exp=%h", obs, exp); end
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h101, 1'b1, 32'h101, instr_of(32'h100)};
    checks++; if (obs !== exp) begin failures++; $display("FAIL same_data got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 1;
    tick(1'b0, 1'b1, 32'hFFFF_FFFF);
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL wrap_redir got=%h exp=%h", obs, exp); end
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL wrap_req got=%h exp=%h", obs, exp); end
    tick(1'b0, 1'b0, 32'h0);
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL wrap_wait got=%h exp=%h", obs, exp); end
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h0, 1'b1, 32'h0, instr_of(32'hFFFF_FFFF)};
    checks++; if (obs !== exp) begin failures++; $display("FAIL wrap_data got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_clr_in_wait();
    do_reset();
    lat = 2;
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL clrw_req0 got=%h exp=%h", obs, exp); end
    CLR = 1'b1;
    tick(1'b0, 1'b0, 32'h0);
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL clrw_clr got=%h exp=%h", obs, exp); end
    CLR = 1'b0;
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL clrw_stale got=%h exp=%h", obs, exp); end
    for (int c = 0; c < 2; c++) begin
      tick(1'b0, 1'b0, 32'h0);
      exp = '0;
      checks++; if (obs !== exp) begin failures++; $display("FAIL clrw_bubble%0d got=%h exp=%h", c, obs, exp); end
    end
    tick(1'b0, 1'b0, 32'h0);
    exp = {1'b1, 32'h1, 1'b1, 32'h1, instr_of(32'h0)};
    checks++; if (obs !== exp) begin failures++; $display("FAIL clrw_data got=%h exp=%h", obs, exp); end
    lat = 1;
  endtask

  initial begin
    imem.IMemReady = 1'b1;
    imem.IMemValid = 1'b0;
    imem.IMemRData = 32'h0;
    @(negedge CLK);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_wrap();
    test_clr_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
